vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Consumes the pixel-rate enable tick from the clock divider and generates VGA raster timing for the snake display.
- Outputs are hsync, vsync, the current pixel coordinates, the visible-region flag, and line/frame start strobes.
- Sits between the pixel-tick divider and the game renderer/VGA pins.
- Runs entirely in the system clock domain; the tick is a clock enable, never a clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in pixels
- H_SYNC, 96, hsync pulse width in pixels
- H_BP, 48, horizontal back porch in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vsync pulse width in lines
- V_BP, 33, vertical back porch in lines
- SYNC_POL, 0, asserted sync level (0 = active-low sync, as for 640x480@60)

Ports:
- clk  input  1  system clock; single clock domain
- reset  input  1  asynchronous, active-low reset
- pixen  input  1  pixel tick from the divider; one clk cycle wide per pixel
- hsync  output  1  horizontal sync, registered
- vsync  output  1  vertical sync, registered
- visible  output  1  high when (hcount, vcount) lies in the active region, registered
- hcount  output  HW=$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)  current pixel column
- vcount  output  VW=$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)  current line
- line_start  output  1  one-clk pulse when hcount becomes 0
- frame_start  output  1  one-clk pulse when (hcount, vcount) becomes (0,0)

Behaviour:
- HTOT = sum of the H_* parameters; VTOT = sum of the V_* parameters. Defaults: HTOT=800, VTOT=525, HW=VW=10.
- Reset (reset low, asynchronous; state held while low):
  - hcount=0, vcount=0, hphase=ACT, vphase=ACT.
  - hsync=vsync=~SYNC_POL, visible=1, line_start=0, frame_start=0.
- pixen=0: every register holds, except line_start and frame_start, which clear to 0.
- pixen=1, hcount advance: if hcount==HTOT-1, hcount goes to 0; otherwise hcount+1.
- pixen=1, vcount advance: vcount changes only when hcount wraps. If vcount==VTOT-1, vcount goes to 0; otherwise vcount+1.
- Horizontal phase FSM (hphase), advances only on pixen:
  - ACT to FP when the next hcount is H_ACTIVE.
  - FP to SYNC when the next hcount is H_ACTIVE+H_FP.
  - SYNC to BP when the next hcount is H_ACTIVE+H_FP+H_SYNC.
  - BP to ACT when hcount wraps.
- Vertical phase FSM (vphase): same structure with the V_* boundaries, advancing only on an hcount wrap.
- Output registers are updated in the same edge as the counters and always reflect the new counter values. No latency exists between hcount/vcount and hsync/vsync/visible.
  - hsync=SYNC_POL iff hphase==SYNC.
  - vsync=SYNC_POL iff vphase==SYNC.
  - visible=1 iff hphase==ACT and vphase==ACT.
- Strobes:
  - line_start=1 for exactly one clk, in the cycle after the edge where hcount wrapped to 0.
  - frame_start=1 under the same rule when both counters wrapped. frame_start implies line_start.
- Sync timing is hsync-edge aligned: vsync changes only on the same edge where hcount wraps to 0.
- Tick rate:
  - pixen held constantly high is legal; counters advance every clk.
  - Irregular pixen gaps only stretch time and never alter the count sequence.
- Reset mid-line or mid-frame aborts immediately. After release, the sequence restarts from (0,0) on the first pixen, with no strobe for the forced (0,0).
- Counters never exceed HTOT-1 or VTOT-1. Phases and counters must stay consistent.
- Any parameter of 0 is illegal; it is caught by an elaboration assertion.

Test Plan:
- Reset then hold pixen=0 for 20 clk -> hcount=0, vcount=0, hsync=vsync=1, visible=1, line_start=frame_start=0 throughout.
- Defaults, pixen every 4th clk, one line -> visible=1 for hcount 0..639 and 0 at 640..799; hsync=0 exactly for hcount 656..751 (96 ticks); line_start pulses once, one clk wide, when hcount reads 0.
- Defaults, pixen constant high, two full frames (840000 clk) -> vsync=0 exactly for vcount 490..491; frame_start pulses once per 420000 clk, coincident with line_start; vcount wraps 524->0.
- Random pixen gaps (0..7 idle clk) over one line -> count sequence and sync positions are identical to the gap-free run; registers hold during gaps; strobes last 1 clk only.
- Assert reset at hcount=300, vcount=100 for 3 clk, asynchronously mid-cycle -> outputs return to reset values without waiting for a clk edge; after release, hcount steps 0,1,2 on successive pixen; no frame_start until the next natural wrap.
- Tiny parameters H=4/1/2/1 and V=3/1/1/1, pixen high -> hcount cycles 0..7; hsync low at hcount 5,6; vsync low at vcount 4; visible only at hcount<4 and vcount<3; frame period 48 clk.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel tick in, raster timing out, between the divider, the timing generator and the renderer.
interface vga_timing_gen_if #(
    parameter int HW = 10,
    parameter int VW = 10
);
    logic          pixen;
    logic          hsync;
    logic          vsync;
    logic          visible;
    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic          line_start;
    logic          frame_start;

    modport master (
        input  pixen,
        output hsync, vsync, visible, hcount, vcount, line_start, frame_start
    );

    modport slave (
        output pixen,
        input  hsync, vsync, visible, hcount, vcount, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters, sync phases and line/frame strobes, advanced by a pixel clock enable.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    vga_timing_gen_if.master vga
);
    localparam int HTOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VTOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW   = $clog2(HTOT);
    localparam int VW   = $clog2(VTOT);
    localparam logic [HW-1:0] H_LAST    = HW'(HTOT - 1);
    localparam logic [HW-1:0] H_TO_FP   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_TO_SYNC = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_TO_BP   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST    = VW'(VTOT - 1);
    localparam logic [VW-1:0] V_TO_FP   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_TO_SYNC = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_TO_BP   = VW'(V_ACTIVE + V_FP + V_SYNC);

    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_param
        $error("vga_timing_gen: every timing parameter must be non-zero");
    end

    typedef enum logic [1:0] {ACT, FP, SYNC, BP} phase_t;

    phase_t        hphase, vphase, hphase_n, vphase_n;
    logic [HW-1:0] hcount_n;
    logic [VW-1:0] vcount_n;
    logic          hwrap, vwrap;

    // Phases are decided from the next counter values so outputs land on the same edge as the counters.
    always_comb begin
        hwrap    = vga.hcount == H_LAST;
        vwrap    = vga.vcount == V_LAST;
        hcount_n = hwrap ? '0 : vga.hcount + 1'b1;
        vcount_n = !hwrap ? vga.vcount : vwrap ? '0 : vga.vcount + 1'b1;
        hphase_n = hwrap ? ACT :
                   hcount_n == H_TO_FP   ? FP   :
                   hcount_n == H_TO_SYNC ? SYNC :
                   hcount_n == H_TO_BP   ? BP   : hphase;
        vphase_n = !hwrap ? vphase :
                   vwrap ? ACT :
                   vcount_n == V_TO_FP   ? FP   :
                   vcount_n == V_TO_SYNC ? SYNC :
                   vcount_n == V_TO_BP   ? BP   : vphase;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vga.hcount      <= '0;
            vga.vcount      <= '0;
            hphase          <= ACT;
            vphase          <= ACT;
            vga.hsync       <= ~SYNC_POL;
            vga.vsync       <= ~SYNC_POL;
            vga.visible     <= 1'b1;
            vga.line_start  <= 1'b0;
            vga.frame_start <= 1'b0;
        end else begin
            vga.line_start  <= vga.pixen && hwrap;
            vga.frame_start <= vga.pixen && hwrap && vwrap;
            if (vga.pixen) begin
                vga.hcount  <= hcount_n;
                vga.vcount  <= vcount_n;
                hphase      <= hphase_n;
                vphase      <= vphase_n;
                vga.hsync   <= hphase_n == SYNC ? SYNC_POL : ~SYNC_POL;
                vga.vsync   <= vphase_n == SYNC ? SYNC_POL : ~SYNC_POL;
                vga.visible <= hphase_n == ACT && vphase_n == ACT;
            end
        end
    end
endmodule
